// File: rtl/alu_pkg.sv
// Shared opcode, instruction-field and sequencer-state definitions for the
// ALU and its issue/writeback sequencer.
package alu_pkg;

    localparam int DW    = 16;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    localparam logic [3:0] OP_LDI = 4'b0000;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_ROL = 4'b0010;
    localparam logic [3:0] OP_ROR = 4'b0011;
    localparam logic [3:0] OP_NOP = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_SGT = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_AND = 4'b1101;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_ADD = 4'b1111;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 9;
    localparam int RS_LSB = 6;
    localparam int RT_LSB = 3;
    localparam int IMM_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_SHL,
            OP_SHR, OP_SLT, OP_SGT, OP_ROL, OP_ROR: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // 0100, 0101 and 0110 are the only encodings left undefined.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0110);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU; opcodes shared with the sequencer via alu_pkg.
module alu
    import alu_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    s,
    output logic [DW-1:0] y
);

    logic [3:0]      sh;
    logic [2*DW-1:0] rol_wide;
    logic [2*DW-1:0] ror_wide;

    assign sh       = b[3:0];
    assign rol_wide = {a, a} << sh;
    assign ror_wide = {a, a} >> sh;

    always_comb begin
        y = '0;
        case (s)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_MUL: y = a * b;
            OP_SHL: y = a << sh;
            OP_SHR: y = a >> sh;
            OP_SLT: y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SGT: y = {{(DW-1){1'b0}}, ($signed(a) > $signed(b))};
            OP_ROL: y = rol_wide[2*DW-1:DW];
            OP_ROR: y = ror_wide[DW-1:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/regfile_8x16.sv
// 8x16 register file: one synchronous write port, two combinational operand
// reads and a combinational debug read; synchronous clear on reset.
module regfile_8x16
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DW-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    q_reg <= wdata;
                end
            end

            assign mem[gi] = q_reg;
        end
    endgenerate

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// Four-state issue/writeback sequencer: accepts an instruction, reads operands,
// drives the external ALU, then writes the result back and updates zero_flag.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_s,
    input  logic [DW-1:0] alu_result,
    output logic          done,
    output logic          illegal,
    output logic          zero_flag,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    state_t        state_reg;
    logic [15:0]   instr_reg;
    logic [DW-1:0] res_reg;
    logic [DW-1:0] alu_a_reg;
    logic [DW-1:0] alu_b_reg;
    logic [3:0]    alu_s_reg;
    logic          done_reg;
    logic          illegal_reg;
    logic          zero_reg;

    logic [3:0]    op;
    logic [2:0]    rd;
    logic [2:0]    rs;
    logic [2:0]    rt;
    logic [DW-1:0] imm;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic          writes_rd;
    logic          rf_we;

    assign op  = instr_reg[OP_LSB +: 4];
    assign rd  = instr_reg[RD_LSB +: 3];
    assign rs  = instr_reg[RS_LSB +: 3];
    assign rt  = instr_reg[RT_LSB +: 3];
    assign imm = {{(DW-IMM_W){1'b0}}, instr_reg[IMM_W-1:0]};

    assign writes_rd = is_alu_op(op) || (op == OP_LDI);
    assign rf_we     = (state_reg == ST_WB) && writes_rd;

    regfile_8x16 u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (res_reg),
        .raddr_a  (rs),
        .rdata_a  (rd_a),
        .raddr_b  (rt),
        .rdata_b  (rd_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Ready is gated by rst so an instruction offered during reset is never taken.
    assign instr_ready = (state_reg == ST_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            instr_reg   <= '0;
            res_reg     <= '0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_s_reg   <= '0;
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            zero_reg    <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_reg <= instr;
                        state_reg <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Operands are captured here, so rd may alias rs or rt.
                    if (is_alu_op(op)) begin
                        alu_a_reg <= rd_a;
                        alu_b_reg <= rd_b;
                        alu_s_reg <= op;
                    end else if (op == OP_LDI) begin
                        alu_s_reg <= OP_LDI;
                    end
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_reg     <= is_alu_op(op) ? alu_result : imm;
                    done_reg    <= 1'b1;
                    illegal_reg <= is_illegal_op(op);
                    state_reg   <= ST_WB;
                end
                ST_WB: begin
                    if (writes_rd) begin
                        zero_reg <= (res_reg == '0);
                    end
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_s     = alu_s_reg;
    assign done      = done_reg;
    assign illegal   = illegal_reg;
    assign zero_flag = zero_reg;

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Multi-cycle issue/writeback sequencer. It is the requesting side of the ALU interface: it drives ALU operands a, b and opcode s, and consumes the ALU result.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from an internal 8x16 register file, issues them to the external combinational ALU, then writes the result back and updates a zero flag.
- Sits between instruction fetch and the ALU in the CPU datapath.

Parameters:
- NREGS, 8, register file depth; fixed at 8 because the instruction has 3-bit register fields.
- DW, 16, datapath width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction presented.
- instr_ready  out  1  sequencer can accept.
- instr  in  16  instruction word.
- alu_a  out  16  ALU operand a.
- alu_b  out  16  ALU operand b.
- alu_s  out  4  ALU opcode.
- alu_result  in  16  ALU combinational result.
- done  out  1  one-cycle pulse per retired instruction.
- illegal  out  1  one-cycle pulse, coincident with done, for an undefined opcode.
- zero_flag  out  1  result of the last retired ALU/LDI instruction was zero.
- dbg_addr  in  3  register file debug read address.
- dbg_data  out  16  combinational read of rf[dbg_addr].

Behaviour:
- Instruction format: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] unused.
- ALU ops and their alu_s codes:
  - ADD 1111, SUB 1110, AND 1101, OR 1100, MUL 0001, SHL 1010, SHR 1011, SLT 1000, SGT 1001, ROL 0010, ROR 0011.
  - For these ops, alu_s = op.
- LDI 0000: rd <= {7'b0, instr[8:0]}. The ALU is not used; alu_s = 0000 and alu_a/alu_b hold their previous values.
- NOP 0111: no register write; zero_flag unchanged.
- Undefined ops 0100, 0101, 0110: no write, zero_flag unchanged, illegal=1 with done.
- FSM states IDLE, DECODE, EXEC, WB:
  - IDLE: instr_ready=1 (forced 0 while rst=1). On instr_valid&instr_ready, latch instr and go to DECODE.
  - DECODE: register alu_a<=rf[rs], alu_b<=rf[rt], alu_s<=op (ALU ops only). Go to EXEC.
  - EXEC: ALU outputs settle; latch res<=alu_result for ALU ops, or res<=LDI immediate. Go to WB.
  - WB: done=1 (and illegal when applicable). Write rf[rd]<=res and zero_flag<=(res==0) for ALU/LDI ops. Go to IDLE.
- Timing and throughput:
  - Handshake at edge E0, then DECODE, EXEC, WB.
  - done is high in the 3rd cycle after E0.
  - The written value appears on dbg_data in the cycle after WB, which is also when instr_ready returns to 1.
  - Throughput: 1 instruction per 4 cycles.
- instr_valid while busy is ignored. The source must hold valid until ready; an instruction not accepted is not lost.
- rd==rs or rd==rt is legal: operands are captured in DECODE, before the write in WB.
- Results are truncated to 16 bits; MUL keeps the low 16 bits. Shift and rotate amounts are interpreted by the ALU.
- All 8 registers are writable; r0 is not hardwired.
- Reset at any state: synchronous. Next state is IDLE and the in-flight instruction is dropped with no write and no done. rf[*]=0, alu_a=alu_b=0, alu_s=0, done=0, illegal=0, zero_flag=0.
- If rst and instr_valid are both high on the same edge, the instruction is not accepted.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode localparams (OP_ADD ... OP_ROR, OP_LDI, OP_NOP).
  - FSM state encoding.
  - Instruction field bit positions.
  - The ALU is updated to use the same opcode constants.
- One natural sub-module, regfile_8x16:
  - Synchronous write port, two combinational read ports plus the debug read port, synchronous reset clear.

Test Plan:
- Reset then LDI r1,5 -> done pulse at E0+3; dbg r1 = 0x0005; zero_flag=0; instr_ready high at E0+4.
- LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> alu_s=1111, alu_a=5, alu_b=3 in EXEC; r3=0x0008.
- SUB r4,r1,r1 -> r4=0x0000, zero_flag=1. A following NOP leaves zero_flag=1 and all registers unchanged.
- Op 0101 -> done and illegal high for one cycle together; no register change; zero_flag unchanged.
- instr_valid held high continuously with 3 back-to-back instructions -> exactly 3 done pulses, 4 cycles apart, none skipped or duplicated.
- rst asserted in EXEC of ADD r5,r1,r2 -> no done pulse; r5=0; all registers 0; instr_ready=1 the cycle after rst drops.
